// File: rtl/uart_rx_timeout_if.sv
// ---------------------------------------------------------------------------
// uart_rx_timeout_if
//   Groups the signals between the RX FIFO / baud generator / line-control
//   config and the character-timeout detector.
//   master : the surrounding UART (drives FIFO status, strobes and config,
//            receives the interrupt source)
//   slave  : the timeout detector itself
// Signals
//   baud_tick      one-cycle oversampling strobe
//   rx_fifo_empty  RX FIFO empty flag, current-cycle value
//   rx_push        character written into the RX FIFO this cycle
//   rx_pop         character read from the RX FIFO this cycle
//   cfg_data_len   0=5,1=6,2=7,3=8 data bits
//   cfg_parity_en  parity bit present
//   cfg_stop_bits  0=1 stop bit, 1=2 stop bits
//   int_rx_timeout registered timeout interrupt source
// ---------------------------------------------------------------------------
interface uart_rx_timeout_if;
  logic       baud_tick;
  logic       rx_fifo_empty;
  logic       rx_push;
  logic       rx_pop;
  logic [1:0] cfg_data_len;
  logic       cfg_parity_en;
  logic       cfg_stop_bits;
  logic       int_rx_timeout;

  modport master (
    output baud_tick, rx_fifo_empty, rx_push, rx_pop,
    output cfg_data_len, cfg_parity_en, cfg_stop_bits,
    input  int_rx_timeout
  );

  modport slave (
    input  baud_tick, rx_fifo_empty, rx_push, rx_pop,
    input  cfg_data_len, cfg_parity_en, cfg_stop_bits,
    output int_rx_timeout
  );
endinterface

// File: rtl/uart_rx_timeout.sv
// ---------------------------------------------------------------------------
// uart_rx_timeout
//   Character-timeout detector for the UART receive path. Raises
//   int_rx_timeout when the RX FIFO holds data and nothing has been pushed
//   or popped for TIMEOUT_CHARS character times, measured in baud ticks.
// Ports
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  uart_rx_timeout_if.slave (FIFO status, strobes, config, interrupt)
// ---------------------------------------------------------------------------
module uart_rx_timeout #(
  parameter int TIMEOUT_CHARS = 4,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_timeout_if.slave   bus
);

  // Sized for the longest frame (12 bits); derived, not a user parameter.
  localparam int CNT_W = $clog2(TIMEOUT_CHARS * TICKS_PER_BIT * 12 + 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    TIMED_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_q;

  logic [3:0]       char_bits;
  logic [CNT_W-1:0] threshold;
  logic [CNT_W-1:0] count_inc;

  // start + data + parity + stop bits; 1.5 stop bits is counted as 2.
  assign char_bits = 4'd7 + {2'b00, bus.cfg_data_len}
                   + {3'b000, bus.cfg_parity_en}
                   + {3'b000, bus.cfg_stop_bits};

  // Re-evaluated every cycle so a config change takes effect mid-count.
  assign threshold = CNT_W'(int'(char_bits) * TICKS_PER_BIT * TIMEOUT_CHARS);

  assign count_inc = count_q + CNT_W'(1);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;

    if (bus.rx_fifo_empty) begin
      // Empty wins even over a push: the push shows up as non-empty next cycle.
      state_d = IDLE;
      count_d = '0;
    end else if (bus.rx_push || bus.rx_pop) begin
      // Any FIFO activity restarts the timer; a coincident tick is dropped.
      state_d = COUNTING;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = COUNTING;
          count_d = '0;
        end
        COUNTING: begin
          if (bus.baud_tick) begin
            count_d = count_inc;
            // >= so a count already past a shrunken threshold fires at once.
            if (count_inc >= threshold) state_d = TIMED_OUT;
          end
        end
        TIMED_OUT: ; // count frozen until empty or activity
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      irq_q   <= (state_d == TIMED_OUT);
    end
  end

  assign bus.int_rx_timeout = irq_q;

endmodule
